fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Shares the write port of one shift FIFO among N_REQ producers, using round-robin arbitration with bounded bursts.
- Each accepted word is tagged with its source ID, so the FIFO is instantiated with width DATA_W+ID_W.
- Sits directly in front of the FIFO. The FIFO `full` output feeds back as fifo_full; the FIFO `write`/`in` inputs are driven from fifo_write/fifo_in.

Parameters:
- N_REQ, 4: number of requesters, 2..16.
- DATA_W, 8: payload width per requester.
- BURST, 4: maximum consecutive grants to one owner before rotation, >=1. BURST=1 gives plain round-robin.
- Localparam ID_W = max(1, clog2(N_REQ)).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low. Deassertion is synchronous to clk, handled externally.
- req  in  N_REQ  per-requester write request; must be held until granted.
- data  in  N_REQ*DATA_W  payloads, flat; requester i occupies bits [i*DATA_W +: DATA_W].
- fifo_full  in  1  full flag from the FIFO.
- grant  out  N_REQ  one-hot or zero, combinational; grant[i] means data[i] is accepted this cycle.
- fifo_write  out  1  equals |grant.
- fifo_in  out  ID_W+DATA_W  {winner_id, data[winner]}; zero when fifo_write=0.
- busy  out  1  registered; 1 while in state BURST.
- owner  out  ID_W  registered; current burst owner, 0 when idle.

Behaviour:
- State: FSM {IDLE, BURST}, rr_ptr[ID_W], owner[ID_W], cnt (holds 0..BURST).
- Reset (rst_n=0, asynchronous):
  - state=IDLE, rr_ptr=0, owner=0, cnt=0, busy=0.
  - grant, fifo_write and fifo_in forced to 0 while rst_n=0, regardless of req.
- Reset mid-burst discards ownership; no partial state survives.
- fifo_full=1: grant=0 and no register changes in either state. A stalled burst keeps its owner and cnt.
- IDLE arbitration: winner = first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ..., N_REQ-1, 0, ... (wraps mod N_REQ, also for non-power-of-2 N_REQ). If no req is set, grant=0 and state is unchanged.
- On IDLE grant:
  - BURST=1: rr_ptr <= (winner+1) mod N_REQ; state stays IDLE.
  - BURST>1: owner <= winner, cnt <= 1, state <= BURST.
- BURST with req[owner]=1 and ~fifo_full:
  - grant owner; cnt <= cnt+1.
  - If cnt+1 == BURST: rr_ptr <= owner+1 mod N_REQ, owner <= 0, cnt <= 0, state <= IDLE.
- BURST with req[owner]=0 (owner released early):
  - Same cycle, no bubble: run IDLE arbitration with a start pointer of owner+1 mod N_REQ.
  - A winner enters a fresh BURST, cnt=1.
  - No winner: state <= IDLE, rr_ptr <= owner+1.
- Exactly one grant per cycle maximum. Throughput is one word/cycle while FIFO not full.
- Latency: req to grant is combinational, 0 cycles. The word is in the FIFO after the next clk edge.
- A single requester may be granted on back-to-back cycles indefinitely if it is the only one requesting. Each burst re-entry still counts from 1.
- Fairness bound: with all requesting and FIFO never full, any requester waits at most (N_REQ-1)*BURST grants.

Decomposition:
- Shared package holds:
  - localparams ST_IDLE/ST_BURST;
  - the ID_W computation function;
  - a helper function for the mod-N_REQ increment.
- One natural sub-module: rr_pick, purely combinational. Inputs req and start pointer; outputs found and winner index. It is instantiated once and reused for both the IDLE and early-release paths by muxing the start pointer.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111 -> grant=0, fifo_write=0, busy=0. Assert rst_n mid-burst (owner=2, cnt=2) -> busy drops immediately, and the next arbitration starts at requester 0.
- BURST=4, req=4'b1111, fifo_full=0 -> grants 0,0,0,0,1,1,1,1,2,...; fifo_in tag matches each grant; busy=1 throughout.
- Early release: requester 1 owns with cnt=2, then req[1] drops and req=4'b1001 -> same cycle grant[3]=1, owner=3, cnt=1.
- Full stall: owner 0 at cnt=2, fifo_full=1 for 3 cycles -> grant=0, owner/cnt unchanged. After full clears -> 2 more grants to 0, then rotation to 1.
- Wrap with N_REQ=3, BURST=1, req=3'b111 -> grant sequence 0,1,2,0,1.
- Sparse: only req[2]=1 for 10 cycles -> 10 consecutive grants to 2, all with fifo_in tag 2; data payload passes through unmodified.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  function automatic int unsigned calc_id_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned inc_mod(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_start, wrapping mod N_REQ.
module fifo_wr_arbiter_rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_start,
  output logic             o_found,
  output logic [ID_W-1:0]  o_winner
);

  always_comb begin
    int unsigned v_idx;
    o_found  = 1'b0;
    o_winner = '0;
    v_idx    = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      // i_start is always < N_REQ, so one subtraction is enough to wrap
      v_idx = 32'(i_start) + k;
      if (v_idx >= N_REQ) v_idx = v_idx - N_REQ;
      if (!o_found && i_req[ID_W'(v_idx)]) begin
        o_found  = 1'b1;
        o_winner = ID_W'(v_idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one FIFO write port; words are tagged with source ID.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter  int unsigned N_REQ  = 4,
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned BURST  = 4,
  localparam int unsigned ID_W   = calc_id_w(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] data,
  input  logic                    fifo_full,
  output logic [N_REQ-1:0]        grant,
  output logic                    fifo_write,
  output logic [ID_W+DATA_W-1:0]  fifo_in,
  output logic                    busy,
  output logic [ID_W-1:0]         owner
);

  localparam int unsigned CNT_W = $clog2(BURST + 1);

  state_e            r_state, w_state_nx;
  logic [ID_W-1:0]   r_rr_ptr, w_rr_ptr_nx;
  logic [ID_W-1:0]   r_owner, w_owner_nx;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nx, w_cnt_inc;
  logic [ID_W-1:0]   w_owner_inc, w_start, w_win, w_gnt_id;
  logic              w_found, w_gnt_vld;
  logic [DATA_W-1:0] w_data [N_REQ];

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) w_data[i] = data[i*DATA_W +: DATA_W];
  end

  assign w_owner_inc = ID_W'(inc_mod(32'(r_owner), N_REQ));
  assign w_cnt_inc   = r_cnt + CNT_W'(1);
  // One picker serves both IDLE arbitration and early release from a burst
  assign w_start     = (r_state == ST_BURST) ? w_owner_inc : r_rr_ptr;

  fifo_wr_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .i_req    (req),
    .i_start  (w_start),
    .o_found  (w_found),
    .o_winner (w_win)
  );

  always_comb begin
    w_state_nx  = r_state;
    w_rr_ptr_nx = r_rr_ptr;
    w_owner_nx  = r_owner;
    w_cnt_nx    = r_cnt;
    w_gnt_vld   = 1'b0;
    w_gnt_id    = '0;
    if (rst_n && !fifo_full) begin
      if (r_state == ST_BURST && req[r_owner]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = r_owner;
        w_cnt_nx  = w_cnt_inc;
        if (w_cnt_inc == CNT_W'(BURST)) begin
          w_state_nx  = ST_IDLE;
          w_rr_ptr_nx = w_owner_inc;
          w_owner_nx  = '0;
          w_cnt_nx    = '0;
        end
      end else if (w_found) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = w_win;
        if (BURST == 1) begin
          w_rr_ptr_nx = ID_W'(inc_mod(32'(w_win), N_REQ));
        end else begin
          w_state_nx = ST_BURST;
          w_owner_nx = w_win;
          w_cnt_nx   = CNT_W'(1);
        end
      end else if (r_state == ST_BURST) begin
        w_state_nx  = ST_IDLE;
        w_rr_ptr_nx = w_owner_inc;
        w_owner_nx  = '0;
        w_cnt_nx    = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_rr_ptr <= w_rr_ptr_nx;
      r_owner  <= w_owner_nx;
      r_cnt    <= w_cnt_nx;
    end
  end

  assign grant      = w_gnt_vld ? (N_REQ'(1) << w_gnt_id) : '0;
  assign fifo_write = w_gnt_vld;
  assign fifo_in    = w_gnt_vld ? {w_gnt_id, w_data[w_gnt_id]} : '0;
  assign busy       = (r_state == ST_BURST);
  assign owner      = r_owner;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a 4-requester burst instance and a 3-requester plain round-robin instance.
module tb_fifo_wr_arbiter;

  typedef struct packed {
    logic [3:0] gnt;
    logic [9:0] fin;
    logic       busy;
    logic [1:0] own;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] data;
  logic        fifo_full;
  logic [3:0]  grant;
  logic        fifo_write;
  logic [9:0]  fifo_in;
  logic        busy;
  logic [1:0]  owner;

  logic [2:0]  req_b;
  logic [23:0] data_b;
  logic        fifo_full_b;
  logic [2:0]  grant_b;
  logic        fifo_write_b;
  logic [9:0]  fifo_in_b;
  logic        busy_b;
  logic [1:0]  owner_b;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.N_REQ(4), .DATA_W(8), .BURST(4)) u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .data       (data),
    .fifo_full  (fifo_full),
    .grant      (grant),
    .fifo_write (fifo_write),
    .fifo_in    (fifo_in),
    .busy       (busy),
    .owner      (owner)
  );

  fifo_wr_arbiter #(.N_REQ(3), .DATA_W(8), .BURST(1)) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req_b),
    .data       (data_b),
    .fifo_full  (fifo_full_b),
    .grant      (grant_b),
    .fifo_write (fifo_write_b),
    .fifo_in    (fifo_in_b),
    .busy       (busy_b),
    .owner      (owner_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered at posedge+1; reset is asserted asynchronously and checked before any edge.
  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'hF;
    req_b = 3'h7;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_fifo_write", 32'(fifo_write), 32'd0);
    check("rst_fifo_in", 32'(fifo_in), 32'd0);
    check("rst_grant_b", 32'(grant_b), 32'd0);
    @(negedge clk);
    check("rst_grant_hold", 32'(grant), 32'd0);
    check("rst_busy_hold", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req   = '0;
    req_b = '0;
  endtask

  // One cycle on instance A; id < 0 means no grant is expected.
  task automatic step(input logic [3:0] r, input logic f, input int id,
                      input logic b, input int own);
    exp_t e;
    req       = r;
    fifo_full = f;
    data      = $urandom;
    e.gnt  = (id < 0) ? 4'h0 : 4'(1 << id);
    e.fin  = '0;
    if (id >= 0) e.fin = {2'(id), data[id*8 +: 8]};
    e.busy = b;
    e.own  = 2'(own);
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check("grant", 32'(grant), 32'(e.gnt));
    check("fifo_write", 32'(fifo_write), 32'(|e.gnt));
    check("fifo_in", 32'(fifo_in), 32'(e.fin));
    check("busy", 32'(busy), 32'(e.busy));
    check("owner", 32'(owner), 32'(e.own));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t eb;
    rst_n       = 1'b0;
    req         = '0;
    req_b       = '0;
    data        = '0;
    data_b      = '0;
    fifo_full   = 1'b0;
    fifo_full_b = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // all requesting: four-word bursts rotating 0,1,2,3
    for (int i = 0; i < 16; i++)
      step(4'hF, 1'b0, i / 4, (i % 4) != 0, ((i % 4) != 0) ? i / 4 : 0);

    // owner 2 at cnt 2, then reset mid-burst; arbitration restarts at 0
    step(4'b0100, 1'b0, 2, 1'b0, 0);
    step(4'b0100, 1'b0, 2, 1'b1, 2);
    do_reset();
    step(4'hF, 1'b0, 0, 1'b0, 0);

    // early release: owner 1 drops, 3 takes over same cycle with a fresh count
    do_reset();
    step(4'b0010, 1'b0, 1, 1'b0, 0);
    step(4'b0010, 1'b0, 1, 1'b1, 1);
    step(4'b1001, 1'b0, 3, 1'b1, 1);
    step(4'b1001, 1'b0, 3, 1'b1, 3);
    step(4'b1001, 1'b0, 3, 1'b1, 3);
    step(4'b1001, 1'b0, 3, 1'b1, 3);
    step(4'b1001, 1'b0, 0, 1'b0, 0);
    // release with no other requester returns to IDLE pointing past the owner
    step(4'b0000, 1'b0, -1, 1'b1, 0);
    step(4'hF, 1'b0, 1, 1'b0, 0);

    // full stall keeps owner 0 at cnt 2, then two more grants and rotation
    do_reset();
    step(4'b0001, 1'b0, 0, 1'b0, 0);
    step(4'b0001, 1'b0, 0, 1'b1, 0);
    for (int i = 0; i < 3; i++) step(4'hF, 1'b1, -1, 1'b1, 0);
    step(4'hF, 1'b0, 0, 1'b1, 0);
    step(4'hF, 1'b0, 0, 1'b1, 0);
    step(4'hF, 1'b0, 1, 1'b0, 0);
    step(4'hF, 1'b1, -1, 1'b1, 1);

    // sparse: only requester 2, granted every cycle, bursts re-entered
    do_reset();
    for (int k = 0; k < 10; k++)
      step(4'b0100, 1'b0, 2, (k % 4) != 0, ((k % 4) != 0) ? 2 : 0);

    // N_REQ=3, BURST=1: plain round-robin wrapping 0,1,2,0,1
    do_reset();
    for (int i = 0; i < 5; i++) begin
      req_b  = 3'b111;
      data_b = 24'($urandom);
      eb.gnt  = 4'(1 << (i % 3));
      eb.fin  = {2'(i % 3), data_b[(i % 3)*8 +: 8]};
      eb.busy = 1'b0;
      eb.own  = 2'd0;
      sb.push_back(eb);
      @(negedge clk);
      eb = sb.pop_front();
      check("grant_b", 32'(grant_b), 32'(eb.gnt));
      check("fifo_in_b", 32'(fifo_in_b), 32'(eb.fin));
      check("busy_b", 32'(busy_b), 32'(eb.busy));
      check("owner_b", 32'(owner_b), 32'(eb.own));
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
